fp_add_arbiter: RTL and testbench

- Shares one pipelined floating-point adder (recoded-core adder wrapper: go/done handshake, 4-cycle go-to-done) among NUM_REQ requesters.
- Arbitrates requests round-robin and drives the adder's operand, go and control inputs.
- Tags each in-flight operation with its requester ID and routes the result and exception flags back to the owning requester.
- Sits between the Calyx-generated FP consumers and a single adder instance.

---
 rtl/fp_add_arbiter.sv | 162 ++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter sharing one pipelined FP adder among NUM_REQ requesters.
// Optional counters: define FP_ADD_ARB_PERF_EN to add perf_issues/perf_stalls.
module fp_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int EXP_W   = 8,
  parameter int SIG_W   = 24,
  parameter int CTRL_W  = 1,
  parameter int LATENCY = 4,
  localparam int WIDTH  = EXP_W + SIG_W,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_left,
  input  logic [NUM_REQ*WIDTH-1:0] req_right,
  input  logic [NUM_REQ-1:0]       req_sub,
  input  logic [NUM_REQ*3-1:0]     req_rm,
  input  logic [CTRL_W-1:0]        control,
  output logic                     add_go,
  output logic [WIDTH-1:0]         add_left,
  output logic [WIDTH-1:0]         add_right,
  output logic                     add_subOp,
  output logic [2:0]               add_rm,
  output logic [CTRL_W-1:0]        add_control,
  input  logic [WIDTH-1:0]         add_out,
  input  logic [4:0]               add_flags,
  input  logic                     add_done,
  output logic [NUM_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]         resp_data,
  output logic [4:0]               resp_flags,
  output logic [ID_W-1:0]          resp_id,
`ifdef FP_ADD_ARB_PERF_EN
  output logic [31:0]              perf_issues,
  output logic [31:0]              perf_stalls,
`endif
  output logic                     tag_err
);

  typedef enum logic {ARB, GO} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] grant_id;
  logic            found;
  int              idx;

  logic            tag_v  [LATENCY];
  logic [ID_W-1:0] tag_id [LATENCY];

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    if (state == ARB) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (!found && ((req_valid >> idx) & NUM_REQ'(1)) != '0) begin
          found    = 1'b1;
          grant_id = ID_W'(idx);
        end
      end
    end
  end

  assign req_ready   = found ? (NUM_REQ'(1) << grant_id) : '0;
  assign add_control = control;

  // Operand registers only change on an accept, which keeps them stable
  // through the go cycle and the cycle after it.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ARB;
      rr_ptr    <= ID_W'(NUM_REQ - 1);
      cur_id    <= '0;
      add_go    <= 1'b0;
      add_left  <= '0;
      add_right <= '0;
      add_subOp <= 1'b0;
      add_rm    <= '0;
    end else begin
      case (state)
        ARB: begin
          if (found) begin
            add_left  <= WIDTH'(req_left >> (grant_id * WIDTH));
            add_right <= WIDTH'(req_right >> (grant_id * WIDTH));
            add_subOp <= 1'(req_sub >> grant_id);
            add_rm    <= 3'(req_rm >> (grant_id * 3));
            cur_id    <= grant_id;
            rr_ptr    <= grant_id;
            add_go    <= 1'b1;
            state     <= GO;
          end
        end
        GO: begin
          add_go <= 1'b0;
          state  <= ARB;
        end
        default: begin
          add_go <= 1'b0;
          state  <= ARB;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < LATENCY; k++) begin
        tag_v[k]  <= 1'b0;
        tag_id[k] <= '0;
      end
    end else begin
      tag_v[0]  <= (state == GO);
      tag_id[0] <= cur_id;
      for (int k = 1; k < LATENCY; k++) begin
        tag_v[k]  <= tag_v[k-1];
        tag_id[k] <= tag_id[k-1];
      end
    end
  end

  // A done without a matching tag (or vice versa) is dropped and flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid <= '0;
      resp_data  <= '0;
      resp_flags <= '0;
      resp_id    <= '0;
      tag_err    <= 1'b0;
    end else begin
      resp_valid <= '0;
      if (add_done && tag_v[LATENCY-1]) begin
        resp_valid <= NUM_REQ'(1) << tag_id[LATENCY-1];
        resp_data  <= add_out;
        resp_flags <= add_flags;
        resp_id    <= tag_id[LATENCY-1];
      end
      if (add_done != tag_v[LATENCY-1]) tag_err <= 1'b1;
    end
  end

`ifdef FP_ADD_ARB_PERF_EN
  logic stall_now;
  assign stall_now = (req_valid != '0) && ((state == GO) || !found);

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_issues <= '0;
      perf_stalls <= '0;
    end else begin
      if (state == GO && perf_issues != '1) perf_issues <= perf_issues + 32'd1;
      if (stall_now && perf_stalls != '1) perf_stalls <= perf_stalls + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_add_arbiter.sv
// Bench for fp_add_arbiter: stub adder with 4-cycle latency, scoreboard model
// of round-robin grants and response timing, directed and random stimulus.
module tb_fp_add_arbiter;
  localparam int N = 4;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [N-1:0]  req_ready;
  logic [N*W-1:0] req_left, req_right;
  logic [N-1:0]  req_sub;
  logic [N*3-1:0] req_rm;
  logic [0:0]    control;
  logic          add_go;
  logic [W-1:0]  add_left, add_right;
  logic          add_subOp;
  logic [2:0]    add_rm;
  logic [0:0]    add_control;
  logic [W-1:0]  add_out;
  logic [4:0]    add_flags;
  logic          add_done;
  logic [N-1:0]  resp_valid;
  logic [W-1:0]  resp_data;
  logic [4:0]    resp_flags;
  logic [1:0]    resp_id;
  logic          tag_err;
  logic          inject_done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  fp_add_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_left(req_left), .req_right(req_right), .req_sub(req_sub), .req_rm(req_rm),
    .control(control), .add_go(add_go), .add_left(add_left), .add_right(add_right),
    .add_subOp(add_subOp), .add_rm(add_rm), .add_control(add_control),
    .add_out(add_out), .add_flags(add_flags), .add_done(add_done),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_flags(resp_flags),
    .resp_id(resp_id), .tag_err(tag_err)
  );

  // Stand-in adder result: real answers for the directed cases, a mix of
  // every operand field otherwise so mis-routed operands show up.
  function automatic logic [36:0] fadd(logic [31:0] l, logic [31:0] r, logic s, logic [2:0] rm);
    if (l == 32'h3F800000 && r == 32'h40000000 && !s) return {5'h00, 32'h40400000};
    if (l == 32'h40400000 && r == 32'h3F800000 && s)  return {5'h00, 32'h40000000};
    if (l == 32'h7F800000 && r == 32'hFF800000 && !s) return {5'h10, 32'h7FC00000};
    return {5'({s, rm, 1'b0}) ^ r[4:0], l ^ {r[15:0], r[31:16]} ^ {s, rm, 28'h0}};
  endfunction

  logic [3:0]  pv;
  logic [31:0] pl [4];
  logic [31:0] pr [4];
  logic        ps [4];
  logic [2:0]  prm [4];

  always @(posedge clk) begin
    if (reset) pv <= '0;
    else begin
      pv <= {pv[2:0], add_go};
      pl[0] <= add_left; pr[0] <= add_right; ps[0] <= add_subOp; prm[0] <= add_rm;
      for (int k = 1; k < 4; k++) begin
        pl[k] <= pl[k-1]; pr[k] <= pr[k-1]; ps[k] <= ps[k-1]; prm[k] <= prm[k-1];
      end
    end
  end

  logic [36:0] stub_res;
  assign stub_res  = pv[3] ? fadd(pl[3], pr[3], ps[3], prm[3]) : {5'h1F, 32'h12345678};
  assign add_done  = pv[3] | inject_done;
  assign add_out   = stub_res[31:0];
  assign add_flags = stub_res[36:32];

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard model: grant order, issue timing, response contents.
  typedef struct { int due; int id; logic [31:0] data; logic [4:0] flags; } exp_t;
  exp_t exq[$];
  int   obs[$];
  int   cyc = 0;
  int   m_ptr = N - 1;
  bit   m_busy = 0, m_go = 0, m_tag_err = 0;
  logic [31:0] last_data = 0;
  logic [4:0]  last_flags = 0;
  int   last_id = 0;

  always @(negedge clk) begin
    if (reset) begin
      exq.delete();
      m_ptr = N - 1; m_busy = 0; m_go = 0; m_tag_err = 0;
      last_data = 0; last_flags = 0; last_id = 0;
    end else begin
      logic [N-1:0] ev;
      int g;
      logic [36:0] r;
      bit legit;
      cyc++;
      ev = '0;
      if (exq.size() > 0 && exq[0].due == cyc) begin
        ev[exq[0].id] = 1'b1;
        last_data = exq[0].data; last_flags = exq[0].flags; last_id = exq[0].id;
        void'(exq.pop_front());
      end
      if (resp_valid != 0) obs.push_back(int'(resp_id));
      chk("resp_valid", 64'(resp_valid), 64'(ev));
      chk("resp_data", 64'(resp_data), 64'(last_data));
      chk("resp_flags", 64'(resp_flags), 64'(last_flags));
      chk("resp_id", 64'(resp_id), 64'(last_id));
      chk("tag_err", 64'(tag_err), 64'(m_tag_err));
      chk("add_go", 64'(add_go), 64'(m_go));
      chk("add_control", 64'(add_control), 64'(control));
      legit = (exq.size() > 0 && exq[0].due == cyc + 1);
      if (add_done != legit) m_tag_err = 1;
      g = -1;
      if (!m_busy)
        for (int k = 1; k <= N; k++)
          if (g < 0 && req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      chk("req_ready", 64'(req_ready), (g >= 0) ? (64'd1 << g) : 64'd0);
      if (g >= 0) begin
        r = fadd(req_left[g*W +: W], req_right[g*W +: W], req_sub[g], req_rm[g*3 +: 3]);
        exq.push_back('{due: cyc + 6, id: g, data: r[31:0], flags: r[36:32]});
        m_ptr = g; m_busy = 1; m_go = 1;
      end else begin
        m_busy = 0; m_go = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  typedef struct { int id; logic [31:0] l; logic [31:0] r; logic s; logic [2:0] rm;
                   logic [31:0] ed; logic [4:0] ef; } vec_t;
  vec_t vt [4];

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    int got;
    reset = 1'b1; req_valid = 0; req_left = 0; req_right = 0; req_sub = 0; req_rm = 0;
    control = 1'b1; inject_done = 0;
    vt[0] = '{0, 32'h3F800000, 32'h40000000, 1'b0, 3'd0, 32'h40400000, 5'h00};
    vt[1] = '{2, 32'h40400000, 32'h3F800000, 1'b1, 3'd0, 32'h40000000, 5'h00};
    vt[2] = '{1, 32'h7F800000, 32'hFF800000, 1'b0, 3'd0, 32'h7FC00000, 5'h10};
    vt[3] = '{3, 32'h3F800000, 32'h40000000, 1'b0, 3'd1, 32'h40400000, 5'h00};
    tick(); tick(); tick();
    chk("reset_resp_valid", 64'(resp_valid), 0);
    chk("reset_tag_err", 64'(tag_err), 0);
    chk("reset_add_go", 64'(add_go), 0);
    reset = 1'b0;

    foreach (vt[i]) begin
      req_left[vt[i].id*W +: W] = vt[i].l;
      req_right[vt[i].id*W +: W] = vt[i].r;
      req_sub[vt[i].id] = vt[i].s;
      req_rm[vt[i].id*3 +: 3] = vt[i].rm;
      req_valid = 4'(1) << vt[i].id;
      tick();
      req_valid = 0;
      got = 0;
      for (int c = 0; c < 20 && got == 0; c++) begin
        tick();
        if (resp_valid != 0) begin
          got = 1;
          chk("vec_valid", 64'(resp_valid), 64'd1 << vt[i].id);
          chk("vec_id", 64'(resp_id), 64'(vt[i].id));
          chk("vec_data", 64'(resp_data), 64'(vt[i].ed));
          chk("vec_flags", 64'(resp_flags), 64'(vt[i].ef));
        end
      end
      chk("vec_response_seen", 64'(got), 1);
      tick();
    end

    // All four requesting continuously from reset.
    do_reset();
    obs.delete();
    for (int i = 0; i < N; i++) req_left[i*W +: W] = 32'h1000_0000 * (i + 1);
    req_valid = 4'hF;
    repeat (10) tick();
    req_valid = 0;
    repeat (10) tick();
    chk("rr_count", 64'(obs.size()), 5);
    for (int i = 0; i < 5; i++) chk("rr_order", (i < obs.size()) ? 64'(obs[i]) : 64'hFF, 64'(i % N));

    // Reset two cycles after an accept discards the op.
    req_valid = 4'b0100;
    tick();
    req_valid = 0;
    tick();
    obs.delete();
    do_reset();
    req_valid = 4'hF;
    #1;
    chk("post_reset_grant", 64'(req_ready), 64'h1);
    tick();
    req_valid = 0;
    repeat (8) tick();
    chk("post_reset_resp_count", 64'(obs.size()), 1);
    chk("post_reset_resp_id", (obs.size() > 0) ? 64'(obs[0]) : 64'hFF, 0);

    // Spurious done with an empty tag pipeline.
    obs.delete();
    inject_done = 1;
    tick();
    inject_done = 0;
    tick();
    chk("tag_err_set", 64'(tag_err), 1);
    repeat (4) tick();
    chk("tag_err_sticky", 64'(tag_err), 1);
    chk("spurious_no_resp", 64'(obs.size()), 0);
    do_reset();
    tick();
    chk("tag_err_cleared", 64'(tag_err), 0);

    // Random traffic.
    for (int c = 0; c < 400; c++) begin
      req_valid = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        req_left[i*W +: W] = $urandom;
        req_right[i*W +: W] = $urandom;
        req_rm[i*3 +: 3] = 3'($urandom_range(0, 7));
      end
      req_sub = 4'($urandom_range(0, 15));
      control = 1'($urandom_range(0, 1));
      tick();
    end
    req_valid = 0;
    repeat (10) tick();
    chk("drain_empty", 64'(exq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
